// File: rtl/qif_spike_rate_monitor.sv
// QIF spike-rate monitor: windowed spike count with burst flag,
// plus inter-spike interval measurement on the neuron spike train.
module qif_spike_rate_monitor #(
   parameter int WINDOW       = 256,
   parameter int CNT_W        = 8,
   parameter int ISI_W        = 16,
   parameter int BURST_THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   output logic [CNT_W-1:0] spike_count,
   output logic             count_valid,
   output logic             burst,
   output logic [ISI_W-1:0] isi,
   output logic             isi_valid
);

   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ISI_W-1:0] ISI_MAX  = '1;

   typedef enum logic {
      S_IDLE,
      S_TRACK
   } state_t;

   logic             r_spike_d;
   logic [CNT_W-1:0] r_acc;
   logic [WIN_W-1:0] r_win_cnt;
   logic [ISI_W-1:0] r_isi_timer;
   state_t           r_state;

   logic             w_event;
   logic             w_close;
   logic [CNT_W-1:0] w_acc_sum;
   logic             w_burst;
   logic [ISI_W-1:0] w_timer_inc;

   // a level held for many cycles yields one event on its rising edge
   assign w_event = spike_in & ~r_spike_d & en;

   // last enabled cycle of the observation window
   assign w_close = en & (r_win_cnt == WIN_LAST);

   // accumulator clamps at all-ones instead of wrapping
   assign w_acc_sum = (r_acc == CNT_MAX) ?
                      r_acc : r_acc + CNT_W'(w_event);

   // widen both sides so thresholds above the count range never fire
   assign w_burst = (32'(w_acc_sum) >= $unsigned(BURST_THRESH));

   // ISI timer clamps at all-ones so long gaps report full scale
   assign w_timer_inc = (r_isi_timer == ISI_MAX) ?
                        r_isi_timer : r_isi_timer + ISI_W'(1);

   // spike delay for edge detection, tracked even while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_spike_d <= 1'b0;
      end else begin
         r_spike_d <= spike_in;
      end
   end

   // window counter, spike accumulator and count/burst result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_win_cnt   <= '0;
         spike_count <= '0;
         burst       <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (en) begin
            if (w_close) begin
               spike_count <= w_acc_sum;
               burst       <= w_burst;
               count_valid <= 1'b1;
               r_acc       <= '0;
               r_win_cnt   <= '0;
            end else begin
               r_acc     <= w_acc_sum;
               r_win_cnt <= r_win_cnt + WIN_W'(1);
            end
         end
      end
   end

   // ISI tracker: first spike arms the timer, later spikes report it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_isi_timer <= '0;
         isi         <= '0;
         isi_valid   <= 1'b0;
      end else begin
         isi_valid <= 1'b0;
         if (en) begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_event) begin
                     r_state     <= S_TRACK;
                     r_isi_timer <= ISI_W'(1);
                  end
               end
               S_TRACK: begin
                  if (w_event) begin
                     isi         <= r_isi_timer;
                     isi_valid   <= 1'b1;
                     r_isi_timer <= ISI_W'(1);
                  end else begin
                     r_isi_timer <= w_timer_inc;
                  end
               end
            endcase
         end
      end
   end

endmodule
